bloom_loader: RTL and testbench
===============================

Name: bloom_loader

Overview:
- Programming sequencer upstream of the Bloom filter's settings interface. It drives `str_len`, `hash`, `hash_mask_val`, `wr_stb`, `wr_data` and `full_clr_stb`, and consumes `ready` and `full_clr_done`.
- It accepts host commands (CLEAR, SET, UNSET) over a valid/ready stream and turns each into exactly one correctly timed filter transaction.
- It provides length checking, a timeout guard and status counters.

Parameters:
- MIN_S, 4, shortest legal pattern length.
- MAX_S, 16, longest legal pattern length.
- HASH_CNT, 10, number of hash lanes.
- HASH_WIDTH, 12, bits per hash address.
- ACK_GUARD, 4, cycles after a strobe during which `ready_i` / `full_clr_done_i` are ignored (covers the filter's register stages).
- TIMEOUT, 4096, maximum cycles spent waiting on the filter before aborting.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  host command valid.
- cmd_ready_o  out  1  loader accepts command this cycle.
- cmd_op_i  in  2  0=NOP, 1=CLEAR, 2=SET (wr_data=1), 3=UNSET (wr_data=0).
- cmd_str_len_i  in  5  pattern length.
- cmd_hash_i  in  HASH_CNT*HASH_WIDTH  hash addresses, lane k in bits [k*HASH_WIDTH +: HASH_WIDTH].
- cmd_hash_mask_i  in  HASH_CNT  per-lane enable.
- str_len_o  out  5  to filter.
- hash_o  out  HASH_CNT*HASH_WIDTH  to filter.
- hash_mask_val_o  out  HASH_CNT  to filter.
- wr_data_o  out  1  to filter.
- wr_stb_o  out  1  one-cycle write strobe.
- full_clr_stb_o  out  1  one-cycle clear strobe.
- ready_i  in  1  filter idle and able to take a write.
- full_clr_done_i  in  1  filter clear finished (pulse or level).
- busy_o  out  1  FSM not in IDLE.
- len_err_o  out  1  sticky: a command had an illegal length.
- timeout_o  out  1  sticky: a wait was aborted.
- wr_cnt_o  out  16  completed SET/UNSET count, saturating at 0xFFFF.
- clr_cnt_o  out  8  completed CLEAR count, saturating at 0xFF.

Behaviour:
- **Reset** (`rst_i`=0 sampled on an edge):
  - FSM returns to IDLE from any state, including mid-wait.
  - All outputs are 0 except `cmd_ready_o`, which is 0 during reset and 1 on the first cycle after reset releases.
  - Counters and sticky flags are cleared. A strobe is never emitted in the cycle reset releases.
- **FSM states:** IDLE, ISSUE, GUARD, WAIT_WR, CLR_GUARD, WAIT_CLR.
- **`cmd_ready_o`** is a registered output, equal to 1 exactly while the FSM is in IDLE. A command is accepted when `cmd_valid_i & cmd_ready_o`.
- **Command decode in IDLE:**
  - NOP: consumed; stay in IDLE; no filter activity.
  - SET or UNSET with `cmd_str_len_i` < MIN_S or > MAX_S: consumed; `len_err_o` is set; stay in IDLE; no strobe.
  - Legal SET or UNSET: latch length, hash, mask and `wr_data` (1 for SET, 0 for UNSET) into the output registers; go to ISSUE.
  - CLEAR: raise `full_clr_stb_o` for exactly the next cycle; go to CLR_GUARD.
- **ISSUE:** if `ready_i`=1, assert `wr_stb_o` for one cycle and go to GUARD; otherwise stay.
- **GUARD / CLR_GUARD:** count ACK_GUARD cycles, then go to WAIT_WR / WAIT_CLR respectively.
- **WAIT_WR:** on `ready_i`=1, increment `wr_cnt_o` and go to IDLE.
- **WAIT_CLR:** on `full_clr_done_i`=1, increment `clr_cnt_o` and go to IDLE.
- **Output hold:** `str_len_o`, `hash_o`, `hash_mask_val_o` and `wr_data_o` stay stable from latch until the next accepted write command. They are not changed by CLEAR.
- **Latency:** acceptance edge to `wr_stb_o`=1 is 1 cycle when `ready_i` is already high. Minimum command-to-command spacing is 1 + 1 + ACK_GUARD + 1 cycles.
- **Timeout:**
  - A single 13-bit wait counter runs in ISSUE, WAIT_WR and WAIT_CLR and resets on every state entry.
  - Reaching TIMEOUT forces IDLE and sets `timeout_o`. The aborted operation does not increment any counter, and no strobe is issued on abort.
- **Simultaneous events:**
  - `ready_i` rising on the same cycle as timeout expiry: completion wins.
  - A `full_clr_done_i` pulse arriving during CLR_GUARD is ignored, by design.
- **`busy_o`** = (state != IDLE), registered.

Test Plan:
- Reset with `rst_i`=0 for 3 cycles while `cmd_valid_i`=1 → all strobes 0 and `cmd_ready_o`=0 throughout; first cycle after release `cmd_ready_o`=1, counters 0.
- SET, len=8, hash lane0=0x123, mask=0x3FF, `ready_i` held 1 → `wr_stb_o`=1 on the cycle after acceptance, `wr_data_o`=1, `hash_o[11:0]`=0x123; `cmd_ready_o` returns after 1+1+4+1 cycles; `wr_cnt_o`=1.
- SET with len=3, then UNSET with len=17 → no `wr_stb_o`; `len_err_o`=1; `wr_cnt_o` unchanged; `cmd_ready_o` never drops.
- CLEAR with `full_clr_done_i` pulsed 2 cycles after the strobe (inside guard), then again 10 cycles later → only the second pulse completes it; `clr_cnt_o`=1.
- UNSET with `ready_i` held 0 → FSM stays in ISSUE; after 4096 cycles it returns to IDLE with `timeout_o`=1, no `wr_stb_o`, `wr_cnt_o`=0.
- Reset asserted while in WAIT_CLR → next cycle all outputs and flags are 0; FSM is in IDLE after release.

Source files
------------

// File: rtl/bloom_loader.sv
// Programming sequencer for the Bloom filter settings port: turns host CLEAR/SET/UNSET
// commands into single, correctly spaced filter transactions with timeout and status counters.
module bloom_loader #(
  parameter int MIN_S      = 4,
  parameter int MAX_S      = 16,
  parameter int HASH_CNT   = 10,
  parameter int HASH_WIDTH = 12,
  parameter int ACK_GUARD  = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [1:0]                     cmd_op_i,
  input  logic [4:0]                     cmd_str_len_i,
  input  logic [HASH_CNT*HASH_WIDTH-1:0] cmd_hash_i,
  input  logic [HASH_CNT-1:0]            cmd_hash_mask_i,
  output logic [4:0]                     str_len_o,
  output logic [HASH_CNT*HASH_WIDTH-1:0] hash_o,
  output logic [HASH_CNT-1:0]            hash_mask_val_o,
  output logic                           wr_data_o,
  output logic                           wr_stb_o,
  output logic                           full_clr_stb_o,
  input  logic                           ready_i,
  input  logic                           full_clr_done_i,
  output logic                           busy_o,
  output logic                           len_err_o,
  output logic                           timeout_o,
  output logic [15:0]                    wr_cnt_o,
  output logic [7:0]                     clr_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, GUARD, WAIT_WR, CLR_GUARD, WAIT_CLR
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_UNSET = 2'd3;

  localparam int GW = (ACK_GUARD > 1) ? $clog2(ACK_GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(ACK_GUARD - 1);
  localparam logic [12:0]   WAIT_LAST  = 13'(TIMEOUT - 1);

  state_t        state;
  logic [GW-1:0] guard_cnt;
  logic [12:0]   wait_cnt;
  logic          accept;
  logic          len_ok;
  logic          wait_expired;

  assign accept       = cmd_valid_i & cmd_ready_o;
  assign len_ok       = (cmd_str_len_i >= 5'(MIN_S)) && (cmd_str_len_i <= 5'(MAX_S));
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Strobes default low so each is a single-cycle pulse; a completion is checked
  // before expiry so a ready arriving on the last wait cycle still counts.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      cmd_ready_o     <= 1'b0;
      busy_o          <= 1'b0;
      str_len_o       <= '0;
      hash_o          <= '0;
      hash_mask_val_o <= '0;
      wr_data_o       <= 1'b0;
      wr_stb_o        <= 1'b0;
      full_clr_stb_o  <= 1'b0;
      len_err_o       <= 1'b0;
      timeout_o       <= 1'b0;
      wr_cnt_o        <= '0;
      clr_cnt_o       <= '0;
      guard_cnt       <= '0;
      wait_cnt        <= '0;
    end else begin
      wr_stb_o       <= 1'b0;
      full_clr_stb_o <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          if (accept) begin
            case (cmd_op_i)
              OP_CLEAR: begin
                full_clr_stb_o <= 1'b1;
                guard_cnt      <= '0;
                state          <= CLR_GUARD;
                cmd_ready_o    <= 1'b0;
                busy_o         <= 1'b1;
              end
              OP_SET, OP_UNSET: begin
                if (len_ok) begin
                  str_len_o       <= cmd_str_len_i;
                  hash_o          <= cmd_hash_i;
                  hash_mask_val_o <= cmd_hash_mask_i;
                  wr_data_o       <= (cmd_op_i == OP_SET);
                  wait_cnt        <= '0;
                  state           <= ISSUE;
                  cmd_ready_o     <= 1'b0;
                  busy_o          <= 1'b1;
                end else begin
                  len_err_o <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ISSUE: begin
          if (ready_i) begin
            wr_stb_o  <= 1'b1;
            guard_cnt <= '0;
            state     <= GUARD;
          end else if (wait_expired) begin
            timeout_o   <= 1'b1;
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 13'd1;
          end
        end
        GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            wait_cnt <= '0;
            state    <= WAIT_WR;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        WAIT_WR: begin
          if (ready_i) begin
            if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else if (wait_expired) begin
            timeout_o   <= 1'b1;
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 13'd1;
          end
        end
        // Done pulses seen here are still from the filter's pipeline, so they are dropped.
        CLR_GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            wait_cnt <= '0;
            state    <= WAIT_CLR;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        WAIT_CLR: begin
          if (full_clr_done_i) begin
            if (clr_cnt_o != 8'hFF) clr_cnt_o <= clr_cnt_o + 8'd1;
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else if (wait_expired) begin
            timeout_o   <= 1'b1;
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 13'd1;
          end
        end
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_loader.sv
// Self-checking bench for bloom_loader: directed timing cases plus a randomized command
// stream compared against a transaction-level model of counters, flags and latched outputs.
module tb_bloom_loader;
  localparam int MIN_S      = 4;
  localparam int MAX_S      = 16;
  localparam int HASH_CNT   = 10;
  localparam int HASH_WIDTH = 12;
  localparam int ACK_GUARD  = 4;
  localparam int TIMEOUT    = 4096;
  localparam int HW         = HASH_CNT * HASH_WIDTH;
  localparam int SPACING    = 1 + 1 + ACK_GUARD + 1;

  logic                clk = 1'b0;
  logic                rst_i = 1'b0;
  logic                cmd_valid_i = 1'b0;
  logic                cmd_ready_o;
  logic [1:0]          cmd_op_i = '0;
  logic [4:0]          cmd_str_len_i = '0;
  logic [HW-1:0]       cmd_hash_i = '0;
  logic [HASH_CNT-1:0] cmd_hash_mask_i = '0;
  logic [4:0]          str_len_o;
  logic [HW-1:0]       hash_o;
  logic [HASH_CNT-1:0] hash_mask_val_o;
  logic                wr_data_o, wr_stb_o, full_clr_stb_o;
  logic                ready_i = 1'b1;
  logic                full_clr_done_i = 1'b0;
  logic                busy_o, len_err_o, timeout_o;
  logic [15:0]         wr_cnt_o;
  logic [7:0]          clr_cnt_o;

  bloom_loader #(
    .MIN_S(MIN_S), .MAX_S(MAX_S), .HASH_CNT(HASH_CNT), .HASH_WIDTH(HASH_WIDTH),
    .ACK_GUARD(ACK_GUARD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_str_len_i(cmd_str_len_i), .cmd_hash_i(cmd_hash_i), .cmd_hash_mask_i(cmd_hash_mask_i),
    .str_len_o(str_len_o), .hash_o(hash_o), .hash_mask_val_o(hash_mask_val_o),
    .wr_data_o(wr_data_o), .wr_stb_o(wr_stb_o), .full_clr_stb_o(full_clr_stb_o),
    .ready_i(ready_i), .full_clr_done_i(full_clr_done_i),
    .busy_o(busy_o), .len_err_o(len_err_o), .timeout_o(timeout_o),
    .wr_cnt_o(wr_cnt_o), .clr_cnt_o(clr_cnt_o)
  );

  always #5 clk = ~clk;

  int seenWrStb  = 0;
  int seenClrStb = 0;
  always @(negedge clk) begin
    if (wr_stb_o === 1'b1) seenWrStb++;
    if (full_clr_stb_o === 1'b1) seenClrStb++;
  end

  int checkCount = 0;
  int passCount  = 0;

  int                  expWrCnt, expClrCnt, expWrStb, expClrStb;
  logic                expLenErr, expTimeout, expWrData;
  logic [4:0]          expStrLen;
  logic [HW-1:0]       expHash;
  logic [HASH_CNT-1:0] expMask;
  bit                  randMode = 1'b0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [HW-1:0] randomHash();
    return HW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic step();
    @(negedge clk);
    if (randMode) begin
      ready_i         = ($urandom_range(0, 1) == 1);
      full_clr_done_i = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic waitIdle(input string tag, input int bound);
    int cycles = 0;
    while (cmd_ready_o !== 1'b1 && cycles < bound) begin
      step();
      cycles++;
    end
    checkOutput(tag, 128'(cmd_ready_o), 128'(1));
  endtask

  // Model: a legal write latches its fields and, if it completes, adds one strobe and one count.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] len, input logic [HW-1:0] hash,
                               input logic [HASH_CNT-1:0] mask, input bit completes);
    cmd_op_i = op; cmd_str_len_i = len; cmd_hash_i = hash; cmd_hash_mask_i = mask;
    cmd_valid_i = 1'b1;
    if (op == 2'd2 || op == 2'd3) begin
      if (int'(len) >= MIN_S && int'(len) <= MAX_S) begin
        expStrLen = len; expHash = hash; expMask = mask; expWrData = (op == 2'd2);
        if (completes) begin
          expWrStb++;
          if (expWrCnt < 65535) expWrCnt++;
        end
      end else begin
        expLenErr = 1'b1;
      end
    end else if (op == 2'd1 && completes) begin
      expClrStb++;
      if (expClrCnt < 255) expClrCnt++;
    end
    step();
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'd0;
  endtask

  task automatic checkModel(input string p);
    checkOutput({p, "_wr_cnt"}, 128'(wr_cnt_o), 128'(expWrCnt));
    checkOutput({p, "_clr_cnt"}, 128'(clr_cnt_o), 128'(expClrCnt));
    checkOutput({p, "_len_err"}, 128'(len_err_o), 128'(expLenErr));
    checkOutput({p, "_timeout"}, 128'(timeout_o), 128'(expTimeout));
    checkOutput({p, "_str_len"}, 128'(str_len_o), 128'(expStrLen));
    checkOutput({p, "_hash"}, 128'(hash_o), 128'(expHash));
    checkOutput({p, "_mask"}, 128'(hash_mask_val_o), 128'(expMask));
    checkOutput({p, "_wr_data"}, 128'(wr_data_o), 128'(expWrData));
    checkOutput({p, "_wr_stbs"}, 128'(seenWrStb), 128'(expWrStb));
    checkOutput({p, "_clr_stbs"}, 128'(seenClrStb), 128'(expClrStb));
  endtask

  // Holds a SET request on the bus through reset and the release edge; it must never be taken.
  task automatic resetDut(input int n);
    rst_i = 1'b0; cmd_valid_i = 1'b1; cmd_op_i = 2'd2; cmd_str_len_i = 5'd8;
    for (int i = 0; i < n; i++) begin
      step();
      checkOutput("rst_cmd_ready", 128'(cmd_ready_o), 128'(0));
      checkOutput("rst_wr_stb", 128'(wr_stb_o), 128'(0));
      checkOutput("rst_clr_stb", 128'(full_clr_stb_o), 128'(0));
      checkOutput("rst_busy", 128'(busy_o), 128'(0));
      checkOutput("rst_flags", 128'({len_err_o, timeout_o}), 128'(0));
      checkOutput("rst_counts", 128'({wr_cnt_o, clr_cnt_o}), 128'(0));
      checkOutput("rst_hash", 128'(hash_o), 128'(0));
    end
    expWrCnt = 0; expClrCnt = 0; expLenErr = 1'b0; expTimeout = 1'b0;
    expStrLen = '0; expHash = '0; expMask = '0; expWrData = 1'b0;
    expWrStb = seenWrStb; expClrStb = seenClrStb;
    rst_i = 1'b1;
    step();
    checkOutput("rel_cmd_ready", 128'(cmd_ready_o), 128'(1));
    checkOutput("rel_wr_stb", 128'(wr_stb_o), 128'(0));
    checkOutput("rel_busy", 128'(busy_o), 128'(0));
    cmd_valid_i = 1'b0; cmd_op_i = 2'd0;
    checkModel("rel");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [HW-1:0] h;
    int cycles;

    resetDut(3);

    // SET with ready held high: strobe one cycle after acceptance, idle again after SPACING cycles.
    ready_i = 1'b1;
    h = randomHash();
    h[11:0] = 12'h123;
    applyStimulus(2'd2, 5'd8, h, 10'h3FF, 1'b1);
    checkOutput("set_stb_early", 128'(wr_stb_o), 128'(0));
    step();
    checkOutput("set_stb", 128'(wr_stb_o), 128'(1));
    checkOutput("set_wr_data", 128'(wr_data_o), 128'(1));
    checkOutput("set_lane0", 128'(hash_o[11:0]), 128'(12'h123));
    step();
    checkOutput("set_stb_once", 128'(wr_stb_o), 128'(0));
    cycles = 3;
    while (cmd_ready_o !== 1'b1 && cycles < 50) begin
      step();
      cycles++;
    end
    checkOutput("set_spacing", 128'(cycles), 128'(SPACING));
    checkModel("set");

    // Illegal lengths are consumed without leaving IDLE.
    applyStimulus(2'd2, 5'd3, randomHash(), 10'h155, 1'b1);
    checkOutput("len3_ready", 128'(cmd_ready_o), 128'(1));
    applyStimulus(2'd3, 5'd17, randomHash(), 10'h2AA, 1'b1);
    checkOutput("len17_ready", 128'(cmd_ready_o), 128'(1));
    repeat (3) step();
    checkModel("len");

    // CLEAR: a done pulse inside the guard is dropped, the later one completes.
    full_clr_done_i = 1'b0;
    applyStimulus(2'd1, 5'd0, '0, '0, 1'b1);
    checkOutput("clr_stb", 128'(full_clr_stb_o), 128'(1));
    step();
    checkOutput("clr_stb_once", 128'(full_clr_stb_o), 128'(0));
    step();
    full_clr_done_i = 1'b1;
    step();
    full_clr_done_i = 1'b0;
    repeat (9) step();
    checkOutput("clr_guard_ignored", 128'(busy_o), 128'(1));
    full_clr_done_i = 1'b1;
    step();
    full_clr_done_i = 1'b0;
    checkOutput("clr_done_ready", 128'(cmd_ready_o), 128'(1));
    checkModel("clr");

    // UNSET with the filter never ready: aborts after TIMEOUT cycles in ISSUE.
    resetDut(2);
    ready_i = 1'b0;
    applyStimulus(2'd3, 5'd10, randomHash(), 10'h0F0, 1'b0);
    cycles = 1;
    while (cmd_ready_o !== 1'b1 && cycles < TIMEOUT + 100) begin
      step();
      cycles++;
    end
    checkOutput("to_cycles", 128'(cycles), 128'(TIMEOUT + 1));
    expTimeout = 1'b1;
    checkModel("to");
    ready_i = 1'b1;

    // Reset while waiting for a clear to finish.
    applyStimulus(2'd1, 5'd0, '0, '0, 1'b0);
    repeat (7) step();
    checkOutput("wclr_busy", 128'(busy_o), 128'(1));
    resetDut(1);
    full_clr_done_i = 1'b1;
    repeat (3) step();
    full_clr_done_i = 1'b0;
    checkOutput("wclr_after_busy", 128'(busy_o), 128'(0));
    checkOutput("wclr_after_cnt", 128'(clr_cnt_o), 128'(0));

    // Random command stream with random filter handshakes.
    randMode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      waitIdle("rnd_idle", 300);
      applyStimulus(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), randomHash(),
                    HASH_CNT'($urandom()), 1'b1);
      if (i % 10 == 9) begin
        waitIdle("rnd_idle", 300);
        checkModel($sformatf("rnd%0d", i));
      end
    end
    randMode = 1'b0;
    ready_i = 1'b1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
